// File: rtl/vx_barrier_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vx_barrier_ctrl
//  Description : Per-core warp barrier controller. Collects warp arrivals per
//                barrier ID, releases local barriers directly and escalates
//                global barriers to the cluster over a valid/ready uplink,
//                releasing them when the cluster responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NUM_CORES    = 4,
  localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int NC_BITS     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int SIZEW       = (NW_BITS > NC_BITS) ? NW_BITS : NC_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  // arrivals from the execute unit
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_BITS-1:0]   req_wid,
  input  logic [NB_BITS-1:0]   req_id,
  input  logic                 req_is_global,
  input  logic [SIZEW-1:0]     req_size_m1,
  // release towards the warp scheduler
  output logic                 release_valid,
  output logic [NB_BITS-1:0]   release_id,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  // cluster uplink
  output logic                 gbar_req_valid,
  input  logic                 gbar_req_ready,
  output logic [NB_BITS-1:0]   gbar_req_id,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_BITS-1:0]   gbar_rsp_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_GPEND   = 2'd2,
    S_GWAIT   = 2'd3
  } bar_state_t;

  bar_state_t           state_q [NUM_BARRIERS];
  bar_state_t           state_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
  logic [SIZEW-1:0]     count_q [NUM_BARRIERS];
  logic [SIZEW-1:0]     count_d [NUM_BARRIERS];
  logic [SIZEW-1:0]     size_q  [NUM_BARRIERS];
  logic [SIZEW-1:0]     size_d  [NUM_BARRIERS];
  logic                 glob_q  [NUM_BARRIERS];
  logic                 glob_d  [NUM_BARRIERS];

  logic                 arr_acc;
  logic [NUM_WARPS-1:0] arr_bit;
  logic [NUM_WARPS-1:0] arr_merged;
  logic [SIZEW:0]       cnt_inc;
  logic                 arr_last;

  logic                 rel_valid_d;
  logic [NB_BITS-1:0]   rel_id_d;
  logic [NUM_WARPS-1:0] rel_mask_d;

  logic                 gsel_valid;
  logic [NB_BITS-1:0]   gsel_id;
  logic                 gbar_hold;

  // Arrivals to entries already escalated stall; a cluster release owns the
  // release path this cycle, so arrivals stall then as well.
  assign req_ready = ~gbar_rsp_valid &
                     ((state_q[req_id] == S_IDLE) | (state_q[req_id] == S_COLLECT));

  assign arr_acc   = req_valid & req_ready;
  assign gbar_hold = gbar_req_valid & ~gbar_req_ready;

  // Next-state of all entries, the release to register and the next uplink pick.
  always_comb begin
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      state_d[i] = state_q[i];
      wmask_d[i] = wmask_q[i];
      count_d[i] = count_q[i];
      size_d[i]  = size_q[i];
      glob_d[i]  = glob_q[i];
    end
    rel_valid_d = 1'b0;
    rel_id_d    = '0;
    rel_mask_d  = '0;
    arr_bit     = NUM_WARPS'(1) << req_wid;
    arr_merged  = wmask_q[req_id] | arr_bit;
    cnt_inc     = {1'b0, count_q[req_id]} + {{SIZEW{1'b0}}, 1'b1};
    arr_last    = (cnt_inc == {1'b0, size_q[req_id]});

    if (arr_acc) begin
      case (state_q[req_id])
        S_IDLE: begin
          size_d[req_id]  = req_size_m1;
          glob_d[req_id]  = req_is_global;
          count_d[req_id] = '0;
          if (req_size_m1 == '0) begin
            // single-warp barrier completes on its first arrival
            if (req_is_global) begin
              state_d[req_id] = S_GPEND;
              wmask_d[req_id] = arr_bit;
            end else begin
              rel_valid_d = 1'b1;
              rel_id_d    = req_id;
              rel_mask_d  = arr_bit;
            end
          end else begin
            state_d[req_id] = S_COLLECT;
            wmask_d[req_id] = arr_bit;
          end
        end
        S_COLLECT: begin
          // a warp already recorded is accepted without counting again
          if ((wmask_q[req_id] & arr_bit) == '0) begin
            if (arr_last) begin
              if (glob_q[req_id]) begin
                state_d[req_id] = S_GPEND;
                wmask_d[req_id] = arr_merged;
              end else begin
                state_d[req_id] = S_IDLE;
                wmask_d[req_id] = '0;
                count_d[req_id] = '0;
                rel_valid_d     = 1'b1;
                rel_id_d        = req_id;
                rel_mask_d      = arr_merged;
              end
            end else begin
              wmask_d[req_id] = arr_merged;
              count_d[req_id] = cnt_inc[SIZEW-1:0];
            end
          end
        end
        default: ;
      endcase
    end

    // cluster release; arrivals are blocked this cycle so no collision
    if (gbar_rsp_valid && (state_q[gbar_rsp_id] == S_GWAIT)) begin
      state_d[gbar_rsp_id] = S_IDLE;
      wmask_d[gbar_rsp_id] = '0;
      count_d[gbar_rsp_id] = '0;
      rel_valid_d          = 1'b1;
      rel_id_d             = gbar_rsp_id;
      rel_mask_d           = wmask_q[gbar_rsp_id];
    end

    if (gbar_req_valid && gbar_req_ready) begin
      state_d[gbar_req_id] = S_GWAIT;
    end

    // lowest-index pending global entry after this cycle's updates
    gsel_valid = 1'b0;
    gsel_id    = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (state_d[i] == S_GPEND) begin
        gsel_valid = 1'b1;
        gsel_id    = NB_BITS'(i);
      end
    end
  end

  // Warps held anywhere, including the mask being released this cycle.
  always_comb begin
    stalled_wmask = release_valid ? release_wmask : '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (state_q[i] != S_IDLE) stalled_wmask = stalled_wmask | wmask_q[i];
    end
  end

  // Entry state, release pulse and uplink request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        state_q[i] <= S_IDLE;
        wmask_q[i] <= '0;
        count_q[i] <= '0;
        size_q[i]  <= '0;
        glob_q[i]  <= 1'b0;
      end
      release_valid  <= 1'b0;
      release_id     <= '0;
      release_wmask  <= '0;
      gbar_req_valid <= 1'b0;
      gbar_req_id    <= '0;
    end else begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        state_q[i] <= state_d[i];
        wmask_q[i] <= wmask_d[i];
        count_q[i] <= count_d[i];
        size_q[i]  <= size_d[i];
        glob_q[i]  <= glob_d[i];
      end
      release_valid <= rel_valid_d;
      release_id    <= rel_id_d;
      release_wmask <= rel_mask_d;
      // the offered request stays fixed until the cluster takes it
      if (gbar_hold) begin
        gbar_req_valid <= 1'b1;
        gbar_req_id    <= gbar_req_id;
      end else begin
        gbar_req_valid <= gsel_valid;
        gbar_req_id    <= gsel_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_barrier_ctrl
//  Description : Directed bench for vx_barrier_ctrl: table of local-barrier
//                vectors plus hand sequences for global and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_barrier_ctrl;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [2:0] req_id;
  logic       req_is_global;
  logic [1:0] req_size_m1;
  logic       release_valid;
  logic [2:0] release_id;
  logic [3:0] release_wmask;
  logic [3:0] stalled_wmask;
  logic       gbar_req_valid;
  logic       gbar_req_ready;
  logic [2:0] gbar_req_id;
  logic       gbar_rsp_valid;
  logic [2:0] gbar_rsp_id;

  int errors = 0;
  int checks = 0;

  vx_barrier_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wid        (req_wid),
    .req_id         (req_id),
    .req_is_global  (req_is_global),
    .req_size_m1    (req_size_m1),
    .release_valid  (release_valid),
    .release_id     (release_id),
    .release_wmask  (release_wmask),
    .stalled_wmask  (stalled_wmask),
    .gbar_req_valid (gbar_req_valid),
    .gbar_req_ready (gbar_req_ready),
    .gbar_req_id    (gbar_req_id),
    .gbar_rsp_valid (gbar_rsp_valid),
    .gbar_rsp_id    (gbar_rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] wid;
    logic [2:0] id;
    logic       g;
    logic [1:0] sz;
    logic       e_rdy;
    logic       e_rv;
    logic [2:0] e_rid;
    logic [3:0] e_rm;
    logic       chk_st;
    logic [3:0] e_st;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wid, input logic [2:0] id,
                       input logic g, input logic [1:0] sz);
    req_valid     = v;
    req_wid       = wid;
    req_id        = id;
    req_is_global = g;
    req_size_m1   = sz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v wid id g sz | rdy rv rid rm chk_st st
    tbl[0]  = '{1'b1, 2'd0, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0001};
    tbl[1]  = '{1'b1, 2'd1, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0011};
    tbl[2]  = '{1'b1, 2'd2, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0111};
    tbl[3]  = '{1'b1, 2'd3, 3'd2, 1'b0, 2'd3, 1'b1, 1'b1, 3'd2, 4'b1111, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 2'd0, 3'd2, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000};
    tbl[5]  = '{1'b1, 2'd1, 3'd0, 1'b0, 2'd0, 1'b1, 1'b1, 3'd0, 4'b0010, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 2'd0, 3'd1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0001};
    tbl[8]  = '{1'b1, 2'd0, 3'd1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0001};
    tbl[9]  = '{1'b1, 2'd1, 3'd1, 1'b0, 2'd1, 1'b1, 1'b1, 3'd1, 4'b0011, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 2'd0, 3'd1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000};

    reset          = 1'b1;
    gbar_req_ready = 1'b0;
    gbar_rsp_valid = 1'b0;
    gbar_rsp_id    = 3'd0;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    // reset state
    chk("rst_release_valid", release_valid, 1'b0);
    chk("rst_release_id", release_id, 3'd0);
    chk("rst_release_wmask", release_wmask, 4'd0);
    chk("rst_stalled", stalled_wmask, 4'd0);
    chk("rst_gbar_valid", gbar_req_valid, 1'b0);
    chk("rst_gbar_id", gbar_req_id, 3'd0);
    chk("rst_req_ready", req_ready, 1'b1);

    // local barriers: full, single-warp and duplicate arrival
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].wid, tbl[i].id, tbl[i].g, tbl[i].sz);
      #1;
      chk("tbl_req_ready", req_ready, tbl[i].e_rdy);
      tick();
      chk("tbl_release_valid", release_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk("tbl_release_id", release_id, tbl[i].e_rid);
        chk("tbl_release_wmask", release_wmask, tbl[i].e_rm);
      end
      if (tbl[i].chk_st) chk("tbl_stalled", stalled_wmask, tbl[i].e_st);
      chk("tbl_gbar_valid", gbar_req_valid, 1'b0);
    end

    // global barrier id=5 with cluster back-pressure
    drive(1'b1, 2'd0, 3'd5, 1'b1, 2'd1);
    tick();
    chk("g5_no_req_yet", gbar_req_valid, 1'b0);
    chk("g5_stalled1", stalled_wmask, 4'b0001);
    drive(1'b1, 2'd1, 3'd5, 1'b1, 2'd1);
    tick();
    chk("g5_stalled2", stalled_wmask, 4'b0011);
    chk("g5_no_local_release", release_valid, 1'b0);
    drive(1'b1, 2'd2, 3'd5, 1'b1, 2'd1);
    for (int k = 0; k < 4; k++) begin
      gbar_req_ready = (k == 3);
      #1;
      chk("g5_req_valid_held", gbar_req_valid, 1'b1);
      chk("g5_req_id_held", gbar_req_id, 3'd5);
      chk("g5_arrival_stalled", req_ready, 1'b0);
      tick();
    end
    gbar_req_ready = 1'b0;
    chk("g5_req_dropped", gbar_req_valid, 1'b0);
    #1;
    chk("g5_gwait_stalled", req_ready, 1'b0);
    drive(1'b1, 2'd0, 3'd0, 1'b0, 2'd1);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 3'd5;
    #1;
    chk("rsp_forces_not_ready", req_ready, 1'b0);
    tick();
    gbar_rsp_valid = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
    chk("g5_release_valid", release_valid, 1'b1);
    chk("g5_release_id", release_id, 3'd5);
    chk("g5_release_wmask", release_wmask, 4'b0011);
    tick();
    chk("g5_release_pulse", release_valid, 1'b0);
    chk("g5_stalled_clear", stalled_wmask, 4'b0000);
    drive(1'b1, 2'd2, 3'd5, 1'b0, 2'd1);
    #1;
    chk("g5_ready_again", req_ready, 1'b1);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);

    // three globals pending; uplink priority by lowest index
    drive(1'b1, 2'd3, 3'd7, 1'b1, 2'd0);
    tick();
    chk("gp_first_id7", gbar_req_id, 3'd7);
    drive(1'b1, 2'd0, 3'd6, 1'b1, 2'd0);
    tick();
    chk("gp_hold_id7a", gbar_req_id, 3'd7);
    drive(1'b1, 2'd1, 3'd3, 1'b1, 2'd0);
    tick();
    chk("gp_hold_id7b", gbar_req_id, 3'd7);
    chk("gp_stalled", stalled_wmask, 4'b1011);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
    gbar_req_ready = 1'b1;
    tick();
    chk("gp_next_valid", gbar_req_valid, 1'b1);
    chk("gp_next_id3", gbar_req_id, 3'd3);
    tick();
    chk("gp_next_id6", gbar_req_id, 3'd6);
    tick();
    gbar_req_ready = 1'b0;
    chk("gp_all_sent", gbar_req_valid, 1'b0);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 3'd6;
    tick();
    chk("gp_rel6_valid", release_valid, 1'b1);
    chk("gp_rel6_id", release_id, 3'd6);
    chk("gp_rel6_mask", release_wmask, 4'b0001);
    gbar_rsp_id = 3'd3;
    tick();
    chk("gp_rel3_id", release_id, 3'd3);
    chk("gp_rel3_mask", release_wmask, 4'b0010);
    gbar_rsp_id = 3'd7;
    tick();
    chk("gp_rel7_id", release_id, 3'd7);
    chk("gp_rel7_mask", release_wmask, 4'b1000);
    gbar_rsp_id = 3'd2;
    tick();
    chk("gp_rsp_idle_ignored", release_valid, 1'b0);
    gbar_rsp_valid = 1'b0;
    chk("gp_stalled_clear", stalled_wmask, 4'b0000);

    // reset in the middle of a collecting local and a pending global
    drive(1'b1, 2'd0, 3'd4, 1'b0, 2'd3);
    tick();
    drive(1'b1, 2'd2, 3'd4, 1'b0, 2'd3);
    tick();
    chk("rm_stalled_collect", stalled_wmask, 4'b0101);
    drive(1'b1, 2'd1, 3'd5, 1'b1, 2'd0);
    tick();
    chk("rm_gbar_pending", gbar_req_valid, 1'b1);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_release_valid", release_valid, 1'b0);
    chk("rm_release_id", release_id, 3'd0);
    chk("rm_release_wmask", release_wmask, 4'd0);
    chk("rm_stalled", stalled_wmask, 4'd0);
    chk("rm_gbar_valid", gbar_req_valid, 1'b0);
    chk("rm_gbar_id", gbar_req_id, 3'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_no_release", release_valid, 1'b0);
      chk("rm_no_gbar", gbar_req_valid, 1'b0);
    end
    drive(1'b1, 2'd1, 3'd4, 1'b0, 2'd1);
    tick();
    chk("rm_fresh_stalled", stalled_wmask, 4'b0010);
    drive(1'b1, 2'd3, 3'd4, 1'b0, 2'd1);
    tick();
    chk("rm_fresh_release", release_valid, 1'b1);
    chk("rm_fresh_id", release_id, 3'd4);
    chk("rm_fresh_mask", release_wmask, 4'b1010);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
    tick();
    chk("rm_fresh_clear", stalled_wmask, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
